synaptic_sram_arbiter: RTL and testbench

SYNAPTIC_SRAM_ARBITER -- requirements
Module: synaptic_sram_arbiter

---
 rtl/synaptic_sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_synaptic_sram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_sram_arbiter.sv
// Synaptic SRAM arbiter: shares one single-port synaptic bank between
// inference reads and learning read-modify-write updates.
//
// Ports:
//   CK, RST                   clock, synchronous active-high reset
//   RD_REQ/RD_ADDR            inference read request (held until RD_GNT)
//   RD_GNT                    read accepted this cycle (combinational)
//   RD_VALID/RD_DATA          read result, one cycle after the grant
//   UPD_REQ/UPD_ADDR/UPD_DELTA  learning update request (held until UPD_GNT)
//   UPD_GNT                   update accepted this cycle (combinational)
//   UPD_DONE                  pulse in the cycle the update write is issued
//   ADDR_ERR                  sticky out-of-range address flag
//   SRAM_CS/WE/A/D, SRAM_Q    single-port bank, 1-cycle read, read-before-write
module synaptic_sram_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TOTAL_DEPTH  = 12544,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned AW          = $clog2(TOTAL_DEPTH)
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  RD_REQ,
  input  logic [AW-1:0]         RD_ADDR,
  output logic                  RD_GNT,
  output logic                  RD_VALID,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  UPD_REQ,
  input  logic [AW-1:0]         UPD_ADDR,
  input  logic [DATA_WIDTH-1:0] UPD_DELTA,
  output logic                  UPD_GNT,
  output logic                  UPD_DONE,
  output logic                  ADDR_ERR,
  output logic                  SRAM_CS,
  output logic                  SRAM_WE,
  output logic [AW-1:0]         SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t                state;
  logic [SW-1:0]         starve_cnt;
  logic [AW-1:0]         upd_addr_q;
  logic [DATA_WIDTH-1:0] upd_delta_q;
  logic                  upd_oor_q;
  logic                  rd_valid_q;
  logic                  rd_oor_q;
  logic                  upd_done_q;
  logic                  addr_err_q;

  logic                  rd_oor;
  logic                  upd_oor;
  logic                  starved;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] sat_sum;

  // Address range checks and starvation condition
  always_comb begin
    rd_oor  = 32'(RD_ADDR) >= 32'(TOTAL_DEPTH);
    upd_oor = 32'(UPD_ADDR) >= 32'(TOTAL_DEPTH);
    starved = starve_cnt == SW'(STARVE_LIMIT);
  end

  // Saturating add of the old word (returned by the RMW read) and the delta
  always_comb begin
    sum     = {SRAM_Q[DATA_WIDTH-1], SRAM_Q} + {upd_delta_q[DATA_WIDTH-1], upd_delta_q};
    sat_sum = sum[DATA_WIDTH-1:0];
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat_sum = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  // Grant arbitration and SRAM port drive
  always_comb begin
    RD_GNT  = 1'b0;
    UPD_GNT = 1'b0;
    SRAM_CS = 1'b0;
    SRAM_WE = 1'b0;
    SRAM_A  = '0;
    SRAM_D  = '0;
    if (!RST) begin
      if (state == IDLE) begin
        if (UPD_REQ && (!RD_REQ || starved)) begin
          UPD_GNT = 1'b1;
          SRAM_CS = !upd_oor;
          SRAM_A  = UPD_ADDR;
        end else if (RD_REQ) begin
          RD_GNT  = 1'b1;
          SRAM_CS = !rd_oor;
          SRAM_A  = RD_ADDR;
        end
      end else begin
        // Write-back half of the RMW; suppressed for an out-of-range address
        SRAM_CS = !upd_oor_q;
        SRAM_WE = !upd_oor_q;
        SRAM_A  = upd_addr_q;
        SRAM_D  = sat_sum;
      end
    end
  end

  // State, starve counter, update latch and registered status
  always_ff @(posedge CK) begin
    if (RST) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      upd_addr_q  <= '0;
      upd_delta_q <= '0;
      upd_oor_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_oor_q    <= 1'b0;
      upd_done_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= RD_GNT;
      rd_oor_q   <= RD_GNT && rd_oor;
      upd_done_q <= UPD_GNT;
      if ((RD_GNT && rd_oor) || (UPD_GNT && upd_oor)) begin
        addr_err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (UPD_GNT) begin
            starve_cnt  <= '0;
            upd_addr_q  <= UPD_ADDR;
            upd_delta_q <= UPD_DELTA;
            upd_oor_q   <= upd_oor;
            state       <= RMW_WR;
          end else if (UPD_REQ && !starved) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is forced to zero unless a valid in-range read completed
  always_comb begin
    RD_VALID = rd_valid_q;
    RD_DATA  = (rd_valid_q && !rd_oor_q) ? SRAM_Q : '0;
    UPD_DONE = upd_done_q;
    ADDR_ERR = addr_err_q;
  end

endmodule

// File: tb/tb_synaptic_sram_arbiter.sv
module tb_synaptic_sram_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 14;

  logic          CK;
  logic          RST;
  logic          RD_REQ;
  logic [AW-1:0] RD_ADDR;
  logic          RD_GNT;
  logic          RD_VALID;
  logic [DW-1:0] RD_DATA;
  logic          UPD_REQ;
  logic [AW-1:0] UPD_ADDR;
  logic [DW-1:0] UPD_DELTA;
  logic          UPD_GNT;
  logic          UPD_DONE;
  logic          ADDR_ERR;
  logic          SRAM_CS;
  logic          SRAM_WE;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] SRAM_D;
  logic [DW-1:0] SRAM_Q;

  logic [DW-1:0] mem [0:16383];

  int total;
  int bad;

  synaptic_sram_arbiter #(
    .DATA_WIDTH  (32),
    .TOTAL_DEPTH (12544),
    .STARVE_LIMIT(8)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .RD_REQ   (RD_REQ),
    .RD_ADDR  (RD_ADDR),
    .RD_GNT   (RD_GNT),
    .RD_VALID (RD_VALID),
    .RD_DATA  (RD_DATA),
    .UPD_REQ  (UPD_REQ),
    .UPD_ADDR (UPD_ADDR),
    .UPD_DELTA(UPD_DELTA),
    .UPD_GNT  (UPD_GNT),
    .UPD_DONE (UPD_DONE),
    .ADDR_ERR (ADDR_ERR),
    .SRAM_CS  (SRAM_CS),
    .SRAM_WE  (SRAM_WE),
    .SRAM_A   (SRAM_A),
    .SRAM_D   (SRAM_D),
    .SRAM_Q   (SRAM_Q)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Single-port SRAM model: registered read, read-before-write
  always @(posedge CK) begin
    if (SRAM_CS) begin
      SRAM_Q <= mem[SRAM_A];
      if (SRAM_WE) mem[SRAM_A] <= SRAM_D;
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    SRAM_Q    = '0;
    RST       = 1'b1;
    RD_REQ    = 1'b1;
    RD_ADDR   = 14'd5;
    UPD_REQ   = 1'b1;
    UPD_ADDR  = 14'd7;
    UPD_DELTA = '0;
    mem[5]    = 32'h0000_0012;
    mem[7]    = 32'd100;
    mem[3]    = 32'h7FFF_FFF0;
    mem[4]    = 32'h8000_0005;

    // Reset: requests ignored, outputs at reset values
    tick();
    tick();
    chk("rst_rd_gnt",   64'(RD_GNT),   64'd0);
    chk("rst_upd_gnt",  64'(UPD_GNT),  64'd0);
    chk("rst_cs",       64'(SRAM_CS),  64'd0);
    chk("rst_rd_valid", 64'(RD_VALID), 64'd0);
    chk("rst_upd_done", 64'(UPD_DONE), 64'd0);
    chk("rst_addr_err", 64'(ADDR_ERR), 64'd0);
    chk("rst_rd_data",  64'(RD_DATA),  64'd0);
    RST     = 1'b0;
    RD_REQ  = 1'b0;
    UPD_REQ = 1'b0;
    #1;
    chk("idle_cs", 64'(SRAM_CS), 64'd0);
    chk("idle_we", 64'(SRAM_WE), 64'd0);
    tick();

    // Plain read of address 5
    RD_REQ  = 1'b1;
    RD_ADDR = 14'd5;
    #1;
    chk("rd_gnt", 64'(RD_GNT),  64'd1);
    chk("rd_cs",  64'(SRAM_CS), 64'd1);
    chk("rd_we",  64'(SRAM_WE), 64'd0);
    chk("rd_a",   64'(SRAM_A),  64'd5);
    tick();
    RD_REQ = 1'b0;
    chk("rd_valid", 64'(RD_VALID), 64'd1);
    chk("rd_data",  64'(RD_DATA),  64'h12);
    tick();
    chk("rd_valid_drop", 64'(RD_VALID), 64'd0);
    chk("rd_data_zero",  64'(RD_DATA),  64'd0);

    // Update mem[7]=100 by -30, then a stalled read of 7 sees 70
    UPD_REQ   = 1'b1;
    UPD_ADDR  = 14'd7;
    UPD_DELTA = -32'sd30;
    #1;
    chk("upd_gnt", 64'(UPD_GNT), 64'd1);
    chk("upd_cs",  64'(SRAM_CS), 64'd1);
    chk("upd_we",  64'(SRAM_WE), 64'd0);
    chk("upd_a",   64'(SRAM_A),  64'd7);
    tick();
    UPD_REQ = 1'b0;
    RD_REQ  = 1'b1;
    RD_ADDR = 14'd7;
    #1;
    chk("rmw_we",     64'(SRAM_WE),  64'd1);
    chk("rmw_cs",     64'(SRAM_CS),  64'd1);
    chk("rmw_a",      64'(SRAM_A),   64'd7);
    chk("rmw_d",      64'(SRAM_D),   64'd70);
    chk("rmw_done",   64'(UPD_DONE), 64'd1);
    chk("rmw_rd_gnt", 64'(RD_GNT),   64'd0);
    chk("rmw_upd_gnt",64'(UPD_GNT),  64'd0);
    tick();
    chk("post_rmw_done",   64'(UPD_DONE), 64'd0);
    chk("post_rmw_rd_gnt", 64'(RD_GNT),   64'd1);
    tick();
    RD_REQ = 1'b0;
    chk("hazard_rd_valid", 64'(RD_VALID), 64'd1);
    chk("hazard_rd_data",  64'(RD_DATA),  64'd70);

    // Positive saturation
    UPD_REQ   = 1'b1;
    UPD_ADDR  = 14'd3;
    UPD_DELTA = 32'h0000_0020;
    #1;
    chk("satp_gnt", 64'(UPD_GNT), 64'd1);
    tick();
    UPD_ADDR  = 14'd4;
    UPD_DELTA = -32'sd16;
    #1;
    chk("satp_d",   64'(SRAM_D),  64'h7FFF_FFFF);
    chk("satp_we",  64'(SRAM_WE), 64'd1);
    chk("satp_no_gnt", 64'(UPD_GNT), 64'd0);
    tick();
    // Negative saturation (back-to-back update)
    #1;
    chk("satn_gnt", 64'(UPD_GNT), 64'd1);
    tick();
    UPD_REQ = 1'b0;
    #1;
    chk("satn_d", 64'(SRAM_D), 64'h8000_0000);
    tick();
    chk("satp_mem", 64'(mem[3]), 64'h7FFF_FFFF);
    chk("satn_mem", 64'(mem[4]), 64'h8000_0000);

    // Starvation: 8 reads win, update wins on the 9th cycle
    RD_REQ    = 1'b1;
    RD_ADDR   = 14'd5;
    UPD_REQ   = 1'b1;
    UPD_ADDR  = 14'd7;
    UPD_DELTA = 32'd1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("starve_rd_gnt",  64'(RD_GNT),  64'd1);
      chk("starve_upd_gnt", 64'(UPD_GNT), 64'd0);
      tick();
    end
    #1;
    chk("starve_win_upd", 64'(UPD_GNT), 64'd1);
    chk("starve_win_rd",  64'(RD_GNT),  64'd0);
    tick();
    #1;
    chk("starve_rmw_rd_gnt", 64'(RD_GNT),  64'd0);
    chk("starve_rmw_we",     64'(SRAM_WE), 64'd1);
    chk("starve_rmw_d",      64'(SRAM_D),  64'd71);
    tick();
    // Counter cleared: read wins again immediately
    #1;
    chk("starve_clr_rd",  64'(RD_GNT),  64'd1);
    chk("starve_clr_upd", 64'(UPD_GNT), 64'd0);
    tick();
    RD_REQ  = 1'b0;
    UPD_REQ = 1'b0;
    tick();

    // Out-of-range read
    chk("pre_oor_err", 64'(ADDR_ERR), 64'd0);
    RD_REQ  = 1'b1;
    RD_ADDR = 14'd12544;
    #1;
    chk("oor_rd_gnt", 64'(RD_GNT),  64'd1);
    chk("oor_rd_cs",  64'(SRAM_CS), 64'd0);
    tick();
    RD_REQ = 1'b0;
    chk("oor_rd_valid", 64'(RD_VALID), 64'd1);
    chk("oor_rd_data",  64'(RD_DATA),  64'd0);
    chk("oor_err",      64'(ADDR_ERR), 64'd1);
    tick();
    tick();
    chk("oor_err_sticky", 64'(ADDR_ERR), 64'd1);

    // Out-of-range update: granted, done pulses, no write
    UPD_REQ   = 1'b1;
    UPD_ADDR  = 14'd13000;
    UPD_DELTA = 32'd5;
    #1;
    chk("oor_upd_gnt", 64'(UPD_GNT), 64'd1);
    chk("oor_upd_cs",  64'(SRAM_CS), 64'd0);
    tick();
    UPD_REQ = 1'b0;
    #1;
    chk("oor_upd_done", 64'(UPD_DONE), 64'd1);
    chk("oor_upd_we",   64'(SRAM_WE),  64'd0);
    chk("oor_upd_wcs",  64'(SRAM_CS),  64'd0);
    tick();

    // Reset while in RMW_WR abandons the write
    UPD_REQ   = 1'b1;
    UPD_ADDR  = 14'd7;
    UPD_DELTA = 32'd10;
    #1;
    chk("rstrmw_gnt", 64'(UPD_GNT), 64'd1);
    tick();
    UPD_REQ = 1'b0;
    RST     = 1'b1;
    #1;
    chk("rstrmw_we", 64'(SRAM_WE), 64'd0);
    chk("rstrmw_cs", 64'(SRAM_CS), 64'd0);
    tick();
    RST = 1'b0;
    chk("rstrmw_mem",      64'(mem[7]),   64'd71);
    chk("rstrmw_done",     64'(UPD_DONE), 64'd0);
    chk("rstrmw_rd_valid", 64'(RD_VALID), 64'd0);
    chk("rstrmw_err",      64'(ADDR_ERR), 64'd0);
    #1;
    chk("rstrmw_idle_cs",  64'(SRAM_CS),  64'd0);
    tick();
    chk("rstrmw_mem_after", 64'(mem[7]), 64'd71);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
